// File: rtl/ser_par_align_pkg.sv
// Shared types and constants for the serial-to-parallel comma aligner.
//   state_t       : alignment FSM states (HUNT / ALIGNED / ACTIVE)
//   COMMA_DEFAULT : default alignment/idle character
//   WORD_W        : parallel word width
//   BIT_CNT_W     : width of the in-word bit position counter
package ser_par_align_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [WORD_W-1:0] COMMA_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

endpackage

// File: rtl/ser_par_align_comma_detect.sv
// Combinational comparison of the current 8-bit window against the comma.
//   word_i  : candidate word (MSB is the oldest bit)
//   match_c : high when word_i equals COMMA
module ser_par_align_comma_detect
    import ser_par_align_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA = COMMA_DEFAULT
) (
    input  logic [WORD_W-1:0] word_i,
    output logic              match_c
);

    assign match_c = (word_i == COMMA);

endmodule

// File: rtl/ser_par_align.sv
// Serial-to-parallel converter that locks word alignment on a comma character.
//   clk         : one serial bit per rising edge
//   reset       : asynchronous active-low reset
//   data_in     : serial stream, MSB of each word first
//   data_out    : last non-comma word received while ACTIVE
//   valid_out   : data_out holds a word received while ACTIVE
//   active      : FSM is in ACTIVE
//   word_strobe : one-cycle pulse at every word boundary once aligned
module ser_par_align
    import ser_par_align_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA        = COMMA_DEFAULT,
    parameter int unsigned       ACTIVE_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic              word_strobe
);

    localparam int unsigned          BC_W   = $clog2(ACTIVE_COUNT + 1);
    localparam logic [BC_W-1:0]      BC_MAX = BC_W'(ACTIVE_COUNT);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_W - 1);

    state_t                state_q, state_d;
    // Only 7 bits of history are kept: the incoming bit completes the word.
    logic [WORD_W-2:0]     sr_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]       bc_cnt_q, bc_cnt_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  active_q, active_d;
    logic                  strobe_q, strobe_d;

    logic [WORD_W-1:0]     word_c;
    logic                  is_comma_c;
    logic                  boundary_c;
    logic [BC_W-1:0]       bc_inc_c;

    assign word_c     = {sr_q, data_in};
    assign boundary_c = (bit_cnt_q == BIT_LAST);
    assign bc_inc_c   = bc_cnt_q + BC_W'(1);

    ser_par_align_comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .word_i  (word_c),
        .match_c (is_comma_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;

        case (state_q)
            HUNT: begin
                // Any bit position may start a word; the match edge is the first boundary.
                if (is_comma_c) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = BC_W'(1);
                    strobe_d  = 1'b1;
                    state_d   = (ACTIVE_COUNT == 1) ? ACTIVE : ALIGNED;
                end
            end

            ALIGNED: begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (boundary_c) begin
                    strobe_d = 1'b1;
                    if (is_comma_c) begin
                        bc_cnt_d = bc_inc_c;
                        if (bc_inc_c == BC_MAX) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        bc_cnt_d = '0;
                        state_d  = HUNT;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (boundary_c) begin
                    strobe_d = 1'b1;
                    if (is_comma_c) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = word_c;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase

        active_d = (state_d == ACTIVE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= word_c[WORD_W-2:0];
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign word_strobe = strobe_q;

endmodule

// File: tb/tb_ser_par_align.sv
// Bench for ser_par_align: a stream-level reference model checked every cycle,
// plus literal expectations for the directed scenarios and an ACTIVE_COUNT=1 instance.
module tb_ser_par_align;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         AC    = 4;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       word_strobe;

    logic [7:0] d1_data_out;
    logic       d1_valid_out;
    logic       d1_active;
    logic       d1_word_strobe;

    int checks = 0;
    int errors = 0;

    ser_par_align #(.COMMA(COMMA), .ACTIVE_COUNT(AC)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .word_strobe (word_strobe)
    );

    ser_par_align #(.COMMA(COMMA), .ACTIVE_COUNT(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (d1_data_out),
        .valid_out   (d1_valid_out),
        .active      (d1_active),
        .word_strobe (d1_word_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the edge index of the lock point and counts commas seen
    // at multiples of 8 edges after it.
    logic [7:0] m_w;
    logic       m_locked;
    int         m_e;
    int         m_lock_e;
    int         m_nc;
    logic       m_act;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_strobe;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_w = 8'h00; m_locked = 1'b0; m_e = 0; m_lock_e = 0; m_nc = 0;
            m_act = 1'b0; m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0;
        end else begin
            m_e      = m_e + 1;
            m_w      = {m_w[6:0], data_in};
            m_strobe = 1'b0;
            if (!m_locked) begin
                if (m_w == COMMA) begin
                    m_locked = 1'b1;
                    m_lock_e = m_e;
                    m_nc     = 1;
                    m_strobe = 1'b1;
                    if (m_nc >= AC) m_act = 1'b1;
                end
            end else if (((m_e - m_lock_e) % 8) == 0) begin
                m_strobe = 1'b1;
                if (m_act) begin
                    if (m_w != COMMA) begin
                        m_data  = m_w;
                        m_valid = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end else if (m_w == COMMA) begin
                    m_nc = m_nc + 1;
                    if (m_nc >= AC) m_act = 1'b1;
                end else begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model data_out",    data_out,          m_data);
        chk("model valid_out",   8'(valid_out),     8'(m_valid));
        chk("model active",      8'(active),        8'(m_act));
        chk("model word_strobe", 8'(word_strobe),   8'(m_strobe));
    end

    // Each bit is driven on a falling edge and sampled by the following rising edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset data_out",    data_out,        8'h00);
        chk("reset valid_out",   8'(valid_out),   8'h00);
        chk("reset active",      8'(active),      8'h00);
        chk("reset word_strobe", 8'(word_strobe), 8'h00);
        reset = 1'b1;

        // Lock on 4 commas, then two data words.
        send_word(8'hBC);
        chk("s1 active after 1 BC",   8'(active),         8'h00);
        chk("s1 lock strobe",         8'(word_strobe),    8'h01);
        chk("ac1 active after 1 BC",  8'(d1_active),      8'h01);
        send_word(8'hBC);
        send_word(8'hBC);
        chk("s1 active after 3 BC",   8'(active),         8'h00);
        send_word(8'hBC);
        chk("s1 active after 4 BC",   8'(active),         8'h01);
        chk("s1 valid after 4 BC",    8'(valid_out),      8'h00);
        send_word(8'hA5);
        chk("s1 data A5",             data_out,           8'hA5);
        chk("s1 valid A5",            8'(valid_out),      8'h01);
        chk("ac1 data A5",            d1_data_out,        8'hA5);
        send_word(8'h3C);
        chk("s1 data 3C",             data_out,           8'h3C);

        // Commas in ACTIVE drop valid but hold data.
        send_word(8'h22);
        chk("s2 data 22",  data_out, 8'h22); chk("s2 valid 22", 8'(valid_out), 8'h01);
        send_word(8'hBC);
        chk("s2 data BC1", data_out, 8'h22); chk("s2 valid BC1", 8'(valid_out), 8'h00);
        send_word(8'hBC);
        chk("s2 data BC2", data_out, 8'h22); chk("s2 valid BC2", 8'(valid_out), 8'h00);
        send_word(8'h33);
        chk("s2 data 33",  data_out, 8'h33); chk("s2 valid 33", 8'(valid_out), 8'h01);

        // Asynchronous reset mid-word while ACTIVE.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2 reset = 1'b0;
        #1;
        chk("s3 async data_out",  data_out,          8'h00);
        chk("s3 async valid_out", 8'(valid_out),     8'h00);
        chk("s3 async active",    8'(active),        8'h00);
        chk("s3 async strobe",    8'(word_strobe),   8'h00);
        @(negedge clk);
        reset = 1'b1;
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        chk("s3 active after 3 BC", 8'(active), 8'h00);
        send_word(8'hBC);
        chk("s3 active after 4 BC", 8'(active), 8'h01);

        // Lock at a 3-bit offset.
        @(negedge clk);
        reset_pulse();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        send_word(8'h7E);
        chk("s4 data 7E",  data_out,        8'h7E);
        chk("s4 valid 7E", 8'(valid_out),   8'h01);
        chk("s4 active",   8'(active),      8'h01);

        // Bad word during ALIGNED returns to HUNT, then relock.
        @(negedge clk);
        reset_pulse();
        send_word(8'hBC); send_word(8'hBC);
        send_word(8'h55);
        chk("s5 active after 55", 8'(active),      8'h00);
        chk("s5 strobe on 55",    8'(word_strobe), 8'h01);
        chk("s5 valid after 55",  8'(valid_out),   8'h00);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        chk("s5 active after 3 BC", 8'(active), 8'h00);
        send_word(8'hBC);
        chk("s5 active after 4 BC", 8'(active), 8'h01);
        send_word(8'h11);
        chk("s5 data 11",  data_out,      8'h11);
        chk("s5 valid 11", 8'(valid_out), 8'h01);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
